// File: rtl/dmem_ctrl_if.sv
// Memory-stage request/response bundle plus the SRAM port of the data-memory responder.
interface dmem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  // Pipeline side
  logic                  memread_M;
  logic                  memwrite_M;
  logic [2:0]            load_store_M;
  logic [31:0]           addr_M;
  logic [DATA_WIDTH-1:0] wdata_M;
  logic                  stall_mem;
  logic                  done;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  misalign;

  // SRAM side
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Controller view
  modport slave (
    input  memread_M, memwrite_M, load_store_M, addr_M, wdata_M, ram_rdata,
    output stall_mem, done, load_data, misalign, ram_en, ram_we, ram_addr, ram_wdata
  );

  // Pipeline + SRAM view
  modport master (
    output memread_M, memwrite_M, load_store_M, addr_M, wdata_M, ram_rdata,
    input  stall_mem, done, load_data, misalign, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory responder: runs one load/store on a synchronous single-port SRAM,
// stalling the pipeline while the access is in flight.
module dmem_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t                state_q, state_d;

  logic                  req_c, bad_addr_c, accept_c, uns_in_c;
  logic [1:0]            size_in_c;

  logic                  st_q, uns_q;
  logic [1:0]            size_q, off_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, load_data_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_WIDTH-1:0] ext_c, lanes_c;
  logic [3:0]            we_c;

  logic                  stall_c, mis_c, done_c, en_c;
  logic [3:0]            ram_we_c;
  logic [DATA_WIDTH-1:0] ram_wdata_c;

  // Address bits above the SRAM range are deliberately ignored (addresses wrap).
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^bus.addr_M[31:ADDR_WIDTH+2];

  // Decode the incoming request: access size, signedness, alignment, acceptance.
  always_comb begin
    size_in_c = SZ_W;
    case (bus.load_store_M)
      3'b000, 3'b001, 3'b101: size_in_c = SZ_B;
      3'b010, 3'b011, 3'b110: size_in_c = SZ_H;
      default:                size_in_c = SZ_W;
    endcase
    uns_in_c   = (bus.load_store_M == 3'b001) || (bus.load_store_M == 3'b011);
    req_c      = bus.memread_M | bus.memwrite_M;
    bad_addr_c = ((size_in_c == SZ_H) && bus.addr_M[0]) ||
                 ((size_in_c == SZ_W) && (bus.addr_M[1:0] != 2'b00));
    accept_c   = (state_q == IDLE) && req_c && !bad_addr_c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; the store wins when both request strobes are high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ACCESS;
      ACCESS:  state_d = st_q ? DONE : WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request, run the read-latency counter and capture load data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= SZ_B;
      off_q       <= 2'b00;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      if (accept_c) begin
        st_q    <= bus.memwrite_M;
        uns_q   <= uns_in_c;
        size_q  <= size_in_c;
        off_q   <= bus.addr_M[1:0];
        waddr_q <= bus.addr_M[ADDR_WIDTH+1:2];
        wdata_q <= bus.wdata_M;
      end
      if (state_q == ACCESS) begin
        cnt_q <= CNT_W'(WAIT_CYCLES);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) load_data_q <= ext_c;
      end
    end
  end

  // Lane steering: byte enables and replicated store data, extended load data.
  always_comb begin
    byte_c = 8'(bus.ram_rdata >> {off_q, 3'b000});
    half_c = 16'(bus.ram_rdata >> {off_q[1], 4'b0000});
    case (size_q)
      SZ_B: begin
        ext_c   = uns_q ? {24'd0, byte_c} : {{24{byte_c[7]}}, byte_c};
        we_c    = 4'b0001 << off_q;
        lanes_c = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        ext_c   = uns_q ? {16'd0, half_c} : {{16{half_c[15]}}, half_c};
        we_c    = 4'b0011 << {off_q[1], 1'b0};
        lanes_c = {2{wdata_q[15:0]}};
      end
      default: begin
        ext_c   = bus.ram_rdata;
        we_c    = 4'b1111;
        lanes_c = wdata_q;
      end
    endcase
  end

  // Per-state outputs; stall and misalign look at the live request only in IDLE.
  always_comb begin
    stall_c     = 1'b0;
    mis_c       = 1'b0;
    done_c      = 1'b0;
    en_c        = 1'b0;
    ram_we_c    = 4'b0000;
    ram_wdata_c = '0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          mis_c   = bad_addr_c | (bus.memread_M & bus.memwrite_M);
          stall_c = !bad_addr_c;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        en_c    = 1'b1;
        if (st_q) begin
          ram_we_c    = we_c;
          ram_wdata_c = lanes_c;
        end
      end
      WAIT:    stall_c = 1'b1;
      DONE:    done_c  = 1'b1;
      default: stall_c = 1'b0;
    endcase
  end

  assign bus.stall_mem = stall_c & rst;
  assign bus.misalign  = mis_c & rst;
  assign bus.done      = done_c;
  assign bus.ram_en    = en_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = waddr_q;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.load_data = load_data_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (read latency 1 and 3) behind one request
// driver, each with its own SRAM model, checked against a byte-level memory model.
module tb_dmem_ctrl;

  localparam int unsigned AW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, sel;
  logic [2:0]  ls;
  logic [31:0] a, wd;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) b1 ();
  dmem_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) b3 ();

  dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  // Requests go only to the selected instance.
  assign b1.memread_M    = rd & ~sel;
  assign b1.memwrite_M   = wr & ~sel;
  assign b1.load_store_M = ls;
  assign b1.addr_M       = a;
  assign b1.wdata_M      = wd;
  assign b3.memread_M    = rd & sel;
  assign b3.memwrite_M   = wr & sel;
  assign b3.load_store_M = ls;
  assign b3.addr_M       = a;
  assign b3.wdata_M      = wd;

  // SRAM models: read data appears exactly N cycles after ram_en, garbage otherwise.
  logic [31:0] mem  [2][4096];
  logic [31:0] pipe [2][3];
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 2; k++) begin
        mem[k][4]  <= 32'h876543A1;
        mem[k][5]  <= 32'h0BADF00D;
        mem[k][6]  <= 32'h00000000;
        mem[k][8]  <= 32'h11223344;
        mem[k][9]  <= 32'h00000000;
        mem[k][12] <= 32'h00000000;
      end
      loaded <= 1'b1;
    end
    pipe[0][0] <= (b1.ram_en && b1.ram_we == 4'b0000) ? mem[0][b1.ram_addr] : 32'hDEADBEEF;
    pipe[1][0] <= (b3.ram_en && b3.ram_we == 4'b0000) ? mem[1][b3.ram_addr] : 32'hDEADBEEF;
    for (int k = 0; k < 2; k++) begin
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
    for (int i = 0; i < 4; i++) begin
      if (b1.ram_en && b1.ram_we[i]) mem[0][b1.ram_addr][8*i +: 8] <= b1.ram_wdata[8*i +: 8];
      if (b3.ram_en && b3.ram_we[i]) mem[1][b3.ram_addr][8*i +: 8] <= b3.ram_wdata[8*i +: 8];
    end
  end

  assign b1.ram_rdata = pipe[0][0];
  assign b3.ram_rdata = pipe[1][2];

  // Outputs of the selected instance.
  logic        o_stall, o_done, o_mis, o_en;
  logic [3:0]  o_we;
  logic [11:0] o_ad;
  logic [31:0] o_wdat, o_ld;
  assign o_stall = sel ? b3.stall_mem : b1.stall_mem;
  assign o_done  = sel ? b3.done      : b1.done;
  assign o_mis   = sel ? b3.misalign  : b1.misalign;
  assign o_en    = sel ? b3.ram_en    : b1.ram_en;
  assign o_we    = sel ? b3.ram_we    : b1.ram_we;
  assign o_ad    = sel ? b3.ram_addr  : b1.ram_addr;
  assign o_wdat  = sel ? b3.ram_wdata : b1.ram_wdata;
  assign o_ld    = sel ? b3.load_data : b1.load_data;

  typedef struct packed {
    logic        stall;
    logic        done;
    logic        mis;
    logic        en;
    logic [3:0]  we;
    logic [11:0] ad;
    logic [31:0] wdat;
    logic [31:0] ld;
  } rec_t;

  rec_t        exq[$];
  logic [31:0] ld_now [2];
  logic [7:0]  refm [16384];
  int          errors = 0;
  int          checks = 0;
  int          run = 0, last_run = 0, prev_run = 0, en_cnt = 0;
  bit          model_en = 1'b0;
  logic [3:0]  snap_we;
  logic [11:0] snap_ad;
  logic [31:0] snap_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare against the model at the falling edge, then advance.
  task automatic step();
    rec_t r;
    @(negedge clk);
    if (model_en) begin
      if (exq.size() != 0) r = exq.pop_front();
      else begin
        r    = '0;
        r.ld = ld_now[sel];
      end
      chk("stall_mem", 32'(o_stall), 32'(r.stall));
      chk("done", 32'(o_done), 32'(r.done));
      chk("misalign", 32'(o_mis), 32'(r.mis));
      chk("ram_en", 32'(o_en), 32'(r.en));
      chk("ram_we", 32'(o_we), 32'(r.we));
      if (r.en) chk("ram_addr", 32'(o_ad), 32'(r.ad));
      if (r.we != 4'b0000) chk("ram_wdata", o_wdat, r.wdat);
      chk("load_data", o_ld, r.ld);
    end
    if (o_en) begin
      en_cnt++;
      snap_we = o_we;
      snap_ad = o_ad;
      snap_wd = o_wdat;
    end
    if (o_stall) run++;
    else if (run != 0) begin
      prev_run = last_run;
      last_run = run;
      run      = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ref(input int adr, input logic [31:0] v);
    for (int i = 0; i < 4; i++) refm[adr + i] = v[8*i +: 8];
  endtask

  // Drive one request and queue the cycle-by-cycle outputs it must produce.
  task automatic issue(input logic rd_i, input logic wr_i, input logic [2:0] ls_i,
                       input logic [31:0] a_i, input logic [31:0] wd_i);
    int          sz, off, base, wc, n;
    bit          bad, sgn;
    rec_t        r;
    logic [63:0] v;
    logic [3:0]  we;
    logic [31:0] lanes;
    rd = rd_i; wr = wr_i; ls = ls_i; a = a_i; wd = wd_i;
    case (ls_i)
      3'b000, 3'b001, 3'b101: sz = 1;
      3'b010, 3'b011, 3'b110: sz = 2;
      default:                sz = 4;
    endcase
    sgn   = (ls_i == 3'b000) || (ls_i == 3'b010);
    off   = int'(a_i % 32'd4);
    base  = int'(a_i % 32'd16384) - off;
    wc    = sel ? 3 : 1;
    bad   = (off % sz) != 0;
    r       = '0;
    r.ld    = ld_now[sel];
    r.mis   = bad || (rd_i && wr_i);
    r.stall = !bad;
    exq.push_back(r);
    if (bad) n = 1;
    else begin
      r.mis = 1'b0;
      r.en  = 1'b1;
      r.ad  = 12'(base / 4);
      if (wr_i) begin
        we    = '0;
        lanes = '0;
        for (int i = 0; i < 4; i++) begin
          we[i]            = (i >= off) && (i < off + sz);
          lanes[8*i +: 8]  = wd_i[8*(i % sz) +: 8];
          if (we[i]) refm[base + i] = lanes[8*i +: 8];
        end
        r.we   = we;
        r.wdat = lanes;
      end
      exq.push_back(r);
      r.en = 1'b0; r.we = '0; r.wdat = '0;
      if (!wr_i) begin
        repeat (wc) exq.push_back(r);
        v = '0;
        for (int k = 0; k < sz; k++) v |= 64'(refm[base + off + k]) << (8 * k);
        if (sgn && v[8*sz-1]) v |= ~((64'd1 << (8 * sz)) - 64'd1);
        ld_now[sel] = v[31:0];
      end
      r.stall = 1'b0;
      r.done  = 1'b1;
      r.ld    = ld_now[sel];
      exq.push_back(r);
      n = wr_i ? 3 : 3 + wc;
    end
    repeat (n) step();
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0;
    step();
  endtask

  // Start an access, pull reset after ncyc cycles, and check everything drops at once.
  task automatic abort(input logic rd_i, input logic wr_i, input logic [2:0] ls_i,
                       input logic [31:0] a_i, input logic [31:0] wd_i,
                       input int ncyc, input logic exp_en);
    model_en = 1'b0;
    exq.delete();
    rd = rd_i; wr = wr_i; ls = ls_i; a = a_i; wd = wd_i;
    repeat (ncyc) step();
    chk("abort_pre_stall", 32'(o_stall), 32'd1);
    chk("abort_pre_en", 32'(o_en), 32'(exp_en));
    rst = 1'b0;
    #1;
    chk("abort_stall", 32'(o_stall), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_mis", 32'(o_mis), 32'd0);
    chk("abort_en", 32'(o_en), 32'd0);
    chk("abort_we", 32'(o_we), 32'd0);
    chk("abort_addr", 32'(o_ad), 32'd0);
    chk("abort_wdata", o_wdat, 32'd0);
    chk("abort_ld", o_ld, 32'd0);
    rd = 1'b0; wr = 1'b0;
    step();
    rst       = 1'b1;
    ld_now[0] = '0;
    ld_now[1] = '0;
    run       = 0;
    model_en  = 1'b1;
  endtask

  int e0;

  initial begin
    rst = 1'b0; sel = 1'b0;
    rd = 1'b1; wr = 1'b0; ls = 3'b010; a = 32'h13; wd = '0;
    ld_now[0] = '0;
    ld_now[1] = '0;
    for (int i = 0; i < 16384; i++) refm[i] = 8'h00;
    set_ref(32'h10, 32'h876543A1);
    set_ref(32'h14, 32'h0BADF00D);
    set_ref(32'h20, 32'h11223344);
    #2;
    // Reset values, with a misaligned request present that must stay masked.
    chk("rst_mis", 32'(o_mis), 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_done", 32'(o_done | b3.done), 32'd0);
    chk("rst_en", 32'(o_en | b3.ram_en), 32'd0);
    chk("rst_we", 32'(o_we | b3.ram_we), 32'd0);
    chk("rst_addr", 32'(o_ad), 32'd0);
    chk("rst_wdata", o_wdat, 32'd0);
    chk("rst_ld", o_ld | b3.load_data, 32'd0);
    ls = 3'b100; a = 32'h10;
    #1;
    chk("rst_stall_aligned", 32'(o_stall), 32'd0);
    rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b1;
    model_en = 1'b1;
    idle();

    // Loads from the preloaded word, read latency 1.
    issue(1, 0, 3'b000, 32'h13, 0);
    chk("lb_lit", o_ld, 32'hFFFFFF87);
    chk("lb_stall_cycles", 32'(last_run), 32'd3);
    idle();
    issue(1, 0, 3'b001, 32'h13, 0);
    chk("lbu_lit", o_ld, 32'h00000087);
    issue(1, 0, 3'b010, 32'h12, 0);
    chk("lh_lit", o_ld, 32'hFFFF8765);
    issue(1, 0, 3'b011, 32'h10, 0);
    chk("lhu_lit", o_ld, 32'h000043A1);
    issue(1, 0, 3'b100, 32'h10, 0);
    chk("lw_lit", o_ld, 32'h876543A1);
    idle();

    // Byte store then readback.
    issue(0, 1, 3'b101, 32'h11, 32'h000000CC);
    chk("sb_we_lit", 32'(snap_we), 32'h2);
    chk("sb_wdata_lit", snap_wd, 32'hCCCCCCCC);
    chk("sb_addr_lit", 32'(snap_ad), 32'h004);
    chk("sb_stall_cycles", 32'(last_run), 32'd2);
    idle();
    issue(1, 0, 3'b100, 32'h10, 0);
    chk("lw_after_sb_lit", o_ld, 32'h8765CCA1);
    idle();

    // Misaligned requests: no access, load_data untouched.
    e0 = en_cnt;
    issue(1, 0, 3'b010, 32'h13, 0);
    issue(1, 0, 3'b100, 32'h12, 0);
    idle();
    chk("misaligned_no_en", 32'(en_cnt - e0), 32'd0);
    chk("misaligned_ld_lit", o_ld, 32'h8765CCA1);

    // Upper address bits wrap.
    issue(1, 0, 3'b100, 32'h00004010, 0);
    chk("wrap_addr_lit", 32'(snap_ad), 32'h004);
    idle();

    // Half store into the upper half, then loads across it.
    issue(0, 1, 3'b110, 32'h1A, 32'h0000BEEF);
    chk("sh_we_lit", 32'(snap_we), 32'hC);
    chk("sh_wdata_lit", snap_wd, 32'hBEEFBEEF);
    issue(1, 0, 3'b100, 32'h18, 0);
    chk("lw_after_sh_lit", o_ld, 32'hBEEF0000);
    issue(1, 0, 3'b011, 32'h1A, 0);
    issue(1, 0, 3'b000, 32'h1A, 0);
    chk("lb_after_sh_lit", o_ld, 32'hFFFFFFEF);
    idle();

    // Both strobes high: performed as a store and flagged.
    issue(1, 1, 3'b111, 32'h30, 32'h5A5A5A5A);
    idle();
    issue(1, 0, 3'b100, 32'h30, 0);
    chk("both_high_store_lit", o_ld, 32'h5A5A5A5A);

    // Back-to-back loads: DONE ignores the held request.
    issue(1, 0, 3'b100, 32'h10, 0);
    issue(1, 0, 3'b001, 32'h11, 0);
    chk("b2b_lbu_lit", o_ld, 32'h000000CC);
    idle();

    // Reset during the WAIT of a load.
    abort(1, 0, 3'b100, 32'h10, 0, 2, 1'b0);
    idle();
    // Reset during the ACCESS of a store: the write must not land.
    abort(0, 1, 3'b111, 32'h14, 32'hFFFFFFFF, 1, 1'b1);
    idle();
    issue(1, 0, 3'b100, 32'h14, 0);
    chk("aborted_store_lit", o_ld, 32'h0BADF00D);
    issue(1, 0, 3'b100, 32'h10, 0);
    chk("post_reset_lw_lit", o_ld, 32'h8765CCA1);
    idle();

    // Read latency 3: load immediately followed by a store.
    sel = 1'b1;
    idle();
    issue(1, 0, 3'b100, 32'h20, 0);
    issue(0, 1, 3'b111, 32'h24, 32'hCAFEF00D);
    chk("wc3_load_stall_lit", 32'(prev_run), 32'd5);
    chk("wc3_store_stall_lit", 32'(last_run), 32'd2);
    chk("wc3_lw_lit", o_ld, 32'h11223344);
    idle();
    issue(1, 0, 3'b100, 32'h24, 0);
    chk("wc3_readback_lit", o_ld, 32'hCAFEF00D);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
